// File: rtl/res_credit_arb.sv
// res_credit_arb
// Shares one pipelined resource among NUM_IN AXI-stream requesters.
// Requests are arbitrated round-robin and held for a whole packet once
// granted. Each requester may have at most MAX_OUT packets outstanding
// in the resource. The granted requester ID is written into the ctl
// field on the way in. Results are steered back to their requester by
// that ID, and the ID field is cleared on the way out.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_val/i_sop/i_eop/i_dat/i_ctl, o_rdy
//                                per-requester request streams
//   o_res_val/sop/eop/dat/ctl, i_res_rdy
//                                registered stream to the resource
//   i_ret_val/sop/eop/dat/ctl, o_ret_rdy
//                                return stream from the resource
//   o_val/o_sop/o_eop/o_dat/o_ctl, i_rdy
//                                per-requester result streams
//   o_cnt                        outstanding packet count per requester
//   o_idle                       nothing outstanding, nothing in flight
//   o_err                        sticky protocol error
module res_credit_arb #(
    parameter int NUM_IN      = 4,
    parameter int DAT_BITS    = 64,
    parameter int CTL_BITS    = 16,
    parameter int OVR_WRT_BIT = 0,
    parameter int MAX_OUT     = 8,
    localparam int IDW        = $clog2(NUM_IN),
    localparam int CW         = $clog2(MAX_OUT + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_IN-1:0]            i_val,
    input  logic [NUM_IN-1:0]            i_sop,
    input  logic [NUM_IN-1:0]            i_eop,
    input  logic [NUM_IN*DAT_BITS-1:0]   i_dat,
    input  logic [NUM_IN*CTL_BITS-1:0]   i_ctl,
    output logic [NUM_IN-1:0]            o_rdy,
    output logic                         o_res_val,
    output logic                         o_res_sop,
    output logic                         o_res_eop,
    output logic [DAT_BITS-1:0]          o_res_dat,
    output logic [CTL_BITS-1:0]          o_res_ctl,
    input  logic                         i_res_rdy,
    input  logic                         i_ret_val,
    input  logic                         i_ret_sop,
    input  logic                         i_ret_eop,
    input  logic [DAT_BITS-1:0]          i_ret_dat,
    input  logic [CTL_BITS-1:0]          i_ret_ctl,
    output logic                         o_ret_rdy,
    output logic [NUM_IN-1:0]            o_val,
    output logic [NUM_IN-1:0]            o_sop,
    output logic [NUM_IN-1:0]            o_eop,
    output logic [NUM_IN*DAT_BITS-1:0]   o_dat,
    output logic [NUM_IN*CTL_BITS-1:0]   o_ctl,
    input  logic [NUM_IN-1:0]            i_rdy,
    output logic [NUM_IN*CW-1:0]         o_cnt,
    output logic                         o_idle,
    output logic                         o_err
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    state_t                state;
    logic [IDW-1:0]        lock_id;
    logic [IDW-1:0]        rr;
    logic [CW-1:0]         cnt [NUM_IN];
    logic                  err;

    logic                  load;
    logic [NUM_IN-1:0]     eligible;
    logic                  win_vld;
    logic [IDW-1:0]        win_id;
    logic [IDW-1:0]        cand;
    logic                  grant_vld;
    logic [IDW-1:0]        grant_id;
    logic                  accept;
    logic                  issue;
    logic                  sel_val;
    logic                  sel_sop;
    logic                  sel_eop;
    logic [DAT_BITS-1:0]   sel_dat;
    logic [CTL_BITS-1:0]   sel_ctl;
    logic [CTL_BITS-1:0]   tag_ctl;

    logic [IDW-1:0]        ret_id;
    logic                  ret_bad;
    logic                  ret_eop_acc;
    logic [CTL_BITS-1:0]   clr_ctl;
    logic [NUM_IN-1:0]     cnt_inc;
    logic [NUM_IN-1:0]     cnt_dec;

    // The output register can take a new beat when it is empty or being
    // drained this cycle, which keeps one beat per cycle with ready held.
    assign load = !o_res_val || i_res_res_rdy_unused_guard();

    function automatic logic i_res_res_rdy_unused_guard();
        return i_res_rdy;
    endfunction

    // A requester may start a packet only while it still has credit left.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            eligible[i] = i_val[i] && i_sop[i] && (cnt[i] < MAX_CNT);
        end
    end

    // Round-robin search starting just after the last winner, wrapping,
    // so a credit-full requester is skipped rather than blocking others.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand = IDW'((int'(rr) + k) % NUM_IN);
            if (!win_vld && eligible[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    // While locked the owner keeps the grant for every beat of its packet,
    // without a credit check, because its credit was taken at sop.
    always_comb begin
        if (state == LOCKED) begin
            grant_vld = 1'b1;
            grant_id  = lock_id;
        end else begin
            grant_vld = win_vld;
            grant_id  = win_id;
        end
    end

    // Pick the granted lane and overwrite its ID field with the grant.
    always_comb begin
        sel_dat = '0;
        sel_ctl = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_dat = i_dat[i*DAT_BITS +: DAT_BITS];
                sel_ctl = i_ctl[i*CTL_BITS +: CTL_BITS];
            end
        end
        sel_val = i_val[grant_id];
        sel_sop = i_sop[grant_id];
        sel_eop = i_eop[grant_id];
        tag_ctl = sel_ctl;
        tag_ctl[OVR_WRT_BIT +: IDW] = grant_id;
    end

    // Ready is withheld during reset so that no requester believes a beat
    // was taken that the reset is about to discard.
    always_comb begin
        o_rdy = '0;
        if (grant_vld && load && !i_rst) begin
            o_rdy[grant_id] = 1'b1;
        end
    end

    assign accept = grant_vld && load && sel_val;
    assign issue  = accept && (state == IDLE);

    // Return path: steer by the ID tag. An ID outside the requester range
    // can only arise for non-power-of-two NUM_IN; such beats are swallowed.
    always_comb begin
        ret_id  = i_ret_ctl[OVR_WRT_BIT +: IDW];
        ret_bad = int'(ret_id) >= NUM_IN;
        clr_ctl = i_ret_ctl;
        clr_ctl[OVR_WRT_BIT +: IDW] = '0;
        o_ret_rdy = ret_bad ? 1'b1 : i_rdy[ret_id];
        o_val = '0;
        if (i_ret_val && !ret_bad) begin
            o_val[ret_id] = 1'b1;
        end
        o_sop = {NUM_IN{i_ret_sop}};
        o_eop = {NUM_IN{i_ret_eop}};
        o_dat = {NUM_IN{i_ret_dat}};
        o_ctl = {NUM_IN{clr_ctl}};
        ret_eop_acc = i_ret_val && !ret_bad && i_rdy[ret_id] && i_ret_eop;
    end

    // Per-requester credit events: a packet start takes a credit, a
    // returned eop gives one back.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            cnt_inc[i] = issue && (grant_id == IDW'(i));
            cnt_dec[i] = ret_eop_acc && (ret_id == IDW'(i));
        end
    end

    // Status outputs.
    always_comb begin
        o_idle = (state == IDLE) && !o_res_val;
        for (int i = 0; i < NUM_IN; i++) begin
            o_cnt[i*CW +: CW] = cnt[i];
            if (cnt[i] != '0) begin
                o_idle = 1'b0;
            end
        end
    end

    assign o_err = err;

    // Arbitration FSM, output register, credit counters and error flag.
    // A simultaneous take and give on the same requester cancel out. A
    // give with no credit outstanding saturates at zero and flags an error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            lock_id   <= '0;
            rr        <= IDW'(NUM_IN - 1);
            err       <= 1'b0;
            o_res_val <= 1'b0;
            o_res_sop <= 1'b0;
            o_res_eop <= 1'b0;
            o_res_dat <= '0;
            o_res_ctl <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (load) begin
                o_res_val <= accept;
                if (accept) begin
                    o_res_sop <= sel_sop;
                    o_res_eop <= sel_eop;
                    o_res_dat <= sel_dat;
                    o_res_ctl <= tag_ctl;
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        rr <= grant_id;
                        if (!sel_eop) begin
                            state   <= LOCKED;
                            lock_id <= grant_id;
                        end
                    end
                end
                LOCKED: begin
                    if (accept && sel_eop) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            for (int i = 0; i < NUM_IN; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else if (cnt_dec[i] && !cnt_inc[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end

            if ((ret_eop_acc && (cnt[ret_id] == '0)) || (i_ret_val && ret_bad)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_res_credit_arb.sv
// tb_res_credit_arb
// Randomized bench for res_credit_arb. Requester drivers and a fake
// resource (which returns each beat inverted, in order) generate traffic.
// A reference model keeps outstanding counts, the packet owner and the
// last winner as plain integers, predicts grants and pushes each expected
// resource beat onto a queue; a separate monitor pops that queue whenever
// the DUT presents a beat to the resource.
module tb_res_credit_arb;

    localparam int N    = 4;
    localparam int DW   = 64;
    localparam int CTLW = 16;
    localparam int OB   = 2;
    localparam int MAXO = 2;
    localparam int CW   = 2;

    typedef struct packed {
        logic [DW-1:0]   dat;
        logic [CTLW-1:0] ctl;
        logic            sop;
        logic            eop;
    } beat_t;

    logic                clk = 1'b0;
    logic                i_rst;
    logic [N-1:0]        i_val, i_sop, i_eop;
    logic [N*DW-1:0]     i_dat;
    logic [N*CTLW-1:0]   i_ctl;
    logic [N-1:0]        o_rdy;
    logic                o_res_val, o_res_sop, o_res_eop;
    logic [DW-1:0]       o_res_dat;
    logic [CTLW-1:0]     o_res_ctl;
    logic                i_res_rdy;
    logic                i_ret_val, i_ret_sop, i_ret_eop;
    logic [DW-1:0]       i_ret_dat;
    logic [CTLW-1:0]     i_ret_ctl;
    logic                o_ret_rdy;
    logic [N-1:0]        o_val, o_sop, o_eop;
    logic [N*DW-1:0]     o_dat;
    logic [N*CTLW-1:0]   o_ctl;
    logic [N-1:0]        i_rdy;
    logic [N*CW-1:0]     o_cnt;
    logic                o_idle, o_err;

    always #5 clk = ~clk;

    res_credit_arb #(
        .NUM_IN(N), .DAT_BITS(DW), .CTL_BITS(CTLW), .OVR_WRT_BIT(OB), .MAX_OUT(MAXO)
    ) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop), .i_dat(i_dat), .i_ctl(i_ctl),
        .o_rdy(o_rdy),
        .o_res_val(o_res_val), .o_res_sop(o_res_sop), .o_res_eop(o_res_eop),
        .o_res_dat(o_res_dat), .o_res_ctl(o_res_ctl), .i_res_rdy(i_res_rdy),
        .i_ret_val(i_ret_val), .i_ret_sop(i_ret_sop), .i_ret_eop(i_ret_eop),
        .i_ret_dat(i_ret_dat), .i_ret_ctl(i_ret_ctl), .o_ret_rdy(o_ret_rdy),
        .o_val(o_val), .o_sop(o_sop), .o_eop(o_eop), .o_dat(o_dat), .o_ctl(o_ctl),
        .i_rdy(i_rdy), .o_cnt(o_cnt), .o_idle(o_idle), .o_err(o_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Traffic knobs (percent chances, packet length limit).
    bit gen_on;
    int gen_pct, val_pct, max_len, res_rdy_pct, ret_rdy_pct, ret_pct;

    // Reference model state.
    int    m_cnt [N];
    int    m_lock;
    int    m_rr;
    bit    m_busy;
    bit    m_err;
    beat_t exp_res[$];

    // Handshake notices from the model to the drivers.
    bit acc_req [N];
    bit ret_taken;

    // Driver state.
    bit    active  [N];
    int    pkt_len [N];
    int    beat_i  [N];
    beat_t ret_q[$];

    localparam logic [CTLW-1:0] ID_MASK = CTLW'(3) << OB;

    task automatic checkOutput(input string name, input logic [127:0] got,
                               input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One cycle of stimulus, called just after each rising edge.
    task automatic applyStimulus();
        if (i_rst) begin
            for (int i = 0; i < N; i++) begin
                active[i]  = 1'b0;
                acc_req[i] = 1'b0;
            end
            i_val     = '0;
            i_ret_val = 1'b0;
            ret_taken = 1'b0;
            ret_q.delete();
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (acc_req[i]) begin
                acc_req[i] = 1'b0;
                i_val[i]   = 1'b0;
                beat_i[i]++;
                if (beat_i[i] == pkt_len[i]) active[i] = 1'b0;
            end
            if (!active[i] && gen_on && ($urandom % 100) < gen_pct) begin
                active[i]  = 1'b1;
                pkt_len[i] = $urandom_range(max_len, 1);
                beat_i[i]  = 0;
            end
            if (active[i] && !i_val[i] && ($urandom % 100) < val_pct) begin
                i_val[i] = 1'b1;
                i_sop[i] = (beat_i[i] == 0);
                i_eop[i] = (beat_i[i] == pkt_len[i] - 1);
                i_dat[i*DW +: DW]     = {$urandom, $urandom};
                i_ctl[i*CTLW +: CTLW] = CTLW'($urandom);
            end
        end
        if (ret_taken) begin
            ret_taken = 1'b0;
            i_ret_val = 1'b0;
            void'(ret_q.pop_front());
        end
        if (!i_ret_val && ret_q.size() > 0 && ($urandom % 100) < ret_pct) begin
            i_ret_val = 1'b1;
            i_ret_dat = ret_q[0].dat;
            i_ret_ctl = ret_q[0].ctl;
            i_ret_sop = ret_q[0].sop;
            i_ret_eop = ret_q[0].eop;
        end
        for (int i = 0; i < N; i++) i_rdy[i] = ($urandom % 100) < ret_rdy_pct;
        i_res_rdy = ($urandom % 100) < res_rdy_pct;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            applyStimulus();
        end
    end

    // Reference model: check the DUT against the model's current view,
    // then advance the model by what will happen at the next rising edge.
    int    g, rid, dec_id, issue_id, c;
    bit    mload, acc, racc;
    logic  [N-1:0] er, ev;
    logic  [N*CW-1:0] ecnt;
    beat_t eb;
    always @(negedge clk) begin
        if (i_rst) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_lock = -1;
            m_rr   = N - 1;
            m_busy = 1'b0;
            m_err  = 1'b0;
            exp_res.delete();
        end else begin
            for (int i = 0; i < N; i++) ecnt[i*CW +: CW] = CW'(m_cnt[i]);
            checkOutput("cnt", o_cnt, ecnt);
            checkOutput("err", o_err, m_err);
            checkOutput("idle", o_idle,
                        (ecnt == '0) && (m_lock < 0) && !m_busy);

            mload = !m_busy || i_res_rdy;
            g = -1;
            if (m_lock >= 0) g = m_lock;
            else for (int k = 1; k <= N; k++) begin
                c = (m_rr + k) % N;
                if (g < 0 && i_val[c] && i_sop[c] && m_cnt[c] < MAXO) g = c;
            end
            er = '0;
            if (g >= 0 && mload) er[g] = 1'b1;
            checkOutput("rdy", o_rdy, er);
            acc = (g >= 0) && mload && i_val[g];

            ev   = '0;
            racc = 1'b0;
            rid  = int'((i_ret_ctl & ID_MASK) >> OB);
            if (i_ret_val) begin
                ev[rid] = 1'b1;
                racc    = i_rdy[rid];
                checkOutput("ret_rdy", o_ret_rdy, i_rdy[rid]);
                checkOutput("ret_dat", o_dat[rid*DW +: DW], i_ret_dat);
                checkOutput("ret_ctl", o_ctl[rid*CTLW +: CTLW], i_ret_ctl & ~ID_MASK);
                checkOutput("ret_sopeop", {o_sop[rid], o_eop[rid]}, {i_ret_sop, i_ret_eop});
            end
            checkOutput("ret_val", o_val, ev);

            issue_id = -1;
            if (acc) begin
                eb.dat = i_dat[g*DW +: DW];
                eb.ctl = (i_ctl[g*CTLW +: CTLW] & ~ID_MASK) | (CTLW'(g) << OB);
                eb.sop = i_sop[g];
                eb.eop = i_eop[g];
                exp_res.push_back(eb);
                if (m_lock < 0) begin
                    issue_id = g;
                    m_rr = g;
                    if (!i_eop[g]) m_lock = g;
                end else if (i_eop[g]) begin
                    m_lock = -1;
                end
                acc_req[g] = 1'b1;
            end
            dec_id = (racc && i_ret_eop) ? rid : -1;
            if (dec_id >= 0 && m_cnt[dec_id] == 0) m_err = 1'b1;
            if (issue_id >= 0 && issue_id != dec_id) m_cnt[issue_id]++;
            if (dec_id >= 0 && dec_id != issue_id && m_cnt[dec_id] > 0) m_cnt[dec_id]--;
            m_busy    = acc || (m_busy && !i_res_rdy);
            ret_taken = racc;
        end
    end

    // Resource-side monitor: every beat the resource takes must be the
    // oldest expected beat; the fake resource queues its inverted result.
    beat_t got_b, exp_b;
    always @(negedge clk) begin
        if (!i_rst && o_res_val && i_res_rdy) begin
            got_b = '{dat: o_res_dat, ctl: o_res_ctl, sop: o_res_sop, eop: o_res_eop};
            if (exp_res.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL res_extra: got %h expected no beat", got_b);
            end else begin
                exp_b = exp_res.pop_front();
                checkOutput("res_beat", got_b, exp_b);
            end
            ret_q.push_back('{dat: ~o_res_dat, ctl: o_res_ctl, sop: o_res_sop, eop: o_res_eop});
        end
    end

    task automatic setKnobs(input int gp, input int vp, input int ml,
                            input int rrp, input int rtp, input int rp);
        gen_pct = gp; val_pct = vp; max_len = ml;
        res_rdy_pct = rrp; ret_rdy_pct = rtp; ret_pct = rp;
    endtask

    task automatic pulseReset();
        @(posedge clk); #2;
        i_rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        i_rst = 1'b0;
        @(negedge clk); #1;
    endtask

    function automatic bit modelQuiet();
        bit q;
        q = (exp_res.size() == 0) && (ret_q.size() == 0) && !i_ret_val
            && (m_lock < 0) && !m_busy;
        for (int i = 0; i < N; i++) if (m_cnt[i] != 0 || active[i]) q = 1'b0;
        return q;
    endfunction

    int waited;
    initial begin
        i_rst = 1'b1;
        i_val = '0; i_sop = '0; i_eop = '0; i_dat = '0; i_ctl = '0;
        i_res_rdy = 1'b0; i_ret_val = 1'b0; i_ret_sop = 1'b0; i_ret_eop = 1'b0;
        i_ret_dat = '0; i_ret_ctl = '0; i_rdy = '0;
        gen_on = 1'b0;
        setKnobs(0, 0, 1, 100, 100, 100);
        repeat (3) @(posedge clk);
        #2;
        i_rst = 1'b0;
        @(negedge clk); #1;
        checkOutput("rst_res_val", o_res_val, 1'b0);
        checkOutput("rst_cnt", o_cnt, '0);
        checkOutput("rst_err", o_err, 1'b0);
        checkOutput("rst_idle", o_idle, 1'b1);
        checkOutput("rst_val", o_val, '0);

        $display("[TB] back-to-back single-beat traffic");
        gen_on = 1'b1;
        setKnobs(100, 100, 1, 100, 100, 100);
        repeat (200) @(posedge clk);

        $display("[TB] mixed random traffic with backpressure");
        setKnobs(60, 70, 4, 70, 70, 50);
        repeat (3000) @(posedge clk);

        $display("[TB] reset in the middle of a packet");
        setKnobs(100, 100, 4, 100, 100, 60);
        waited = 0;
        while (m_lock < 0 && waited < 500) begin
            @(posedge clk);
            waited++;
        end
        if (m_lock < 0) begin
            n_cmp++; n_bad++;
            $display("[TB] FAIL lock_wait: got no locked packet expected one within 500 cycles");
        end
        pulseReset();
        checkOutput("mid_rst_res_val", o_res_val, 1'b0);
        checkOutput("mid_rst_cnt", o_cnt, '0);
        repeat (500) @(posedge clk);

        $display("[TB] draining");
        gen_on = 1'b0;
        setKnobs(0, 100, 4, 100, 100, 100);
        waited = 0;
        while (!modelQuiet() && waited < 3000) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk); #1;
        checkOutput("drain_done", modelQuiet(), 1'b1);
        checkOutput("drain_idle", o_idle, 1'b1);

        $display("[TB] return eop with no credit outstanding");
        @(posedge clk); #2;
        ret_q.push_back('{dat: 64'h0123_4567_89ab_cdef, ctl: 16'h0, sop: 1'b1, eop: 1'b1});
        repeat (6) @(posedge clk);
        @(negedge clk); #1;
        checkOutput("err_sticky", o_err, 1'b1);
        checkOutput("err_cnt", o_cnt, '0);
        pulseReset();
        checkOutput("err_cleared", o_err, 1'b0);
        checkOutput("err_idle", o_idle, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/res_credit_arb.md
Name: res_credit_arb

Overview:
- Shares one pipelined resource (e.g. a multiplier) among NUM_IN AXI-stream requesters.
- Arbitration is round-robin and packet-locked.
- Each requester has an outstanding-packet credit limit, so one requester cannot flood the resource's return path.
- The requester ID is tagged into ctl; returned results are demuxed back to the originating requester by that tag, and the tag field is cleared on the way out.
- Sits between requester cores and the shared resource, in place of a plain arb/demux pair.

Parameters:
- NUM_IN, 4, number of requesters (≥2).
- DAT_BITS, 64, data width.
- CTL_BITS, 16, ctl width.
- OVR_WRT_BIT, 0, LSB of the ID field in ctl. IDW = $clog2(NUM_IN).
- MAX_OUT, 8, maximum outstanding packets per requester. CW = $clog2(MAX_OUT+1).

Ports:
- i_clk  in  1  clock. Single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_val/i_sop/i_eop  in  NUM_IN  request streams (per requester).
- i_dat  in  NUM_IN*DAT_BITS  request data.
- i_ctl  in  NUM_IN*CTL_BITS  request ctl.
- o_rdy  out  NUM_IN  request ready.
- o_res_val/o_res_sop/o_res_eop  out  1  to resource.
- o_res_dat  out  DAT_BITS  to resource.
- o_res_ctl  out  CTL_BITS  to resource.
- i_res_rdy  in  1  resource ready.
- i_ret_val/i_ret_sop/i_ret_eop  in  1  from resource.
- i_ret_dat  in  DAT_BITS  from resource.
- i_ret_ctl  in  CTL_BITS  from resource.
- o_ret_rdy  out  1  ready to resource.
- o_val/o_sop/o_eop  out  NUM_IN  results to requesters.
- o_dat  out  NUM_IN*DAT_BITS  result data.
- o_ctl  out  NUM_IN*CTL_BITS  result ctl.
- i_rdy  in  NUM_IN  requester ready.
- o_cnt  out  NUM_IN*CW  outstanding count per requester.
- o_idle  out  1  all counts zero and FSM in IDLE.
- o_err  out  1  sticky protocol error.

Behaviour:
- Reset:
  - All o_*val = 0, o_cnt = 0, o_err = 0, o_idle = 1.
  - FSM = IDLE; rr pointer = NUM_IN-1, so requester 0 has first priority.
  - Reset mid-packet drops the lock and clears all counts and registered outputs; no partial beat is emitted after reset.
- Eligibility: requester i is eligible when i_val[i] && i_sop[i] && cnt[i] < MAX_OUT.
- Output stage:
  - o_res_* is a single register stage.
  - load = !o_res_val || i_res_rdy.
  - Latency: 1 cycle from accepted request beat to o_res_val.
  - Full throughput of 1 beat/cycle is required when i_res_rdy is held at 1.
- FSM IDLE:
  - Winner = first eligible requester scanning from rr+1 upward, with wrap.
  - o_rdy[winner] = load; all other o_rdy = 0.
  - On an accepted beat: rr ← winner; cnt[winner] increments.
  - If that beat has eop = 0, go to LOCKED with lock_id = winner. If eop = 1 (single-beat packet), stay in IDLE.
  - No eligible requester: no o_rdy is asserted.
- FSM LOCKED:
  - o_rdy[lock_id] = load; all others 0. The credit check is not applied.
  - Accepted eop beat → IDLE.
- Tagging:
  - o_res_ctl = accepted i_ctl with bits [OVR_WRT_BIT +: IDW] replaced by the granted ID.
  - dat, sop and eop pass through unchanged.
- Return demux (combinational):
  - id = i_ret_ctl[OVR_WRT_BIT +: IDW].
  - o_val[id] = i_ret_val. Every o_dat/o_sop/o_eop lane carries the return beat.
  - o_ctl has the ID field forced to 0.
  - o_ret_rdy = i_rdy[id].
- Credit return:
  - On an accepted return beat with eop = 1, cnt[id] decrements.
  - Same-cycle issue sop and return eop on the same ID leave cnt unchanged.
- Errors (o_err sticky until reset):
  - id ≥ NUM_IN (non-power-of-2 NUM_IN): beat is dropped, o_ret_rdy = 1, no o_val asserted, o_err set.
  - Return eop when cnt[id] = 0: cnt stays at 0 (saturates), beat is still delivered, o_err set.
- Credit-full requester: o_rdy[i] stays low until a credit returns. The arbiter skips it without stalling other requesters.
- o_idle = (all cnt == 0) && FSM == IDLE && !o_res_val.

Test Plan:
- Reset, then all 4 requesters raise single-beat packets continuously with i_res_rdy = 1 → grant order 0,1,2,3,0,…; o_res_val first appears 1 cycle after the first accept; ctl ID bits read 0,1,2,3.
- Requester 2 sends a 3-beat packet while requester 0 is valid → 3 consecutive beats from 2 with no interleave; requester 0 is granted on the cycle after eop.
- MAX_OUT = 2, requester 1 issues 3 packets with no returns → third packet stalls with o_cnt[1] = 2 while others are still granted; a return eop with ID 1 brings cnt to 1 and the third packet issues.
- Return beat with ctl ID = 3 while i_rdy[3] = 0 for 2 cycles → o_ret_rdy = 0 for those cycles; o_val[3] = 1; o_ctl[3] ID field = 0; no other o_val asserted.
- Return eop for ID 0 with cnt[0] = 0 → o_err = 1 (sticky), cnt[0] stays 0; after i_rst pulse o_err = 0 and o_idle = 1.
- Assert i_rst mid 4-beat packet, then release → o_res_val = 0 the cycle after reset, FSM in IDLE, and the next grant goes to requester 0.
